// File: rtl/axi_lite_up_bridge.sv
// AXI4-Lite slave to up_ipif master bridge: one outstanding write and one outstanding
// read, each issuing a single-cycle up_* request and waiting (bounded) for its ack.
module axi_lite_up_bridge #(
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [C_ADDR_WIDTH+1:0]   s_axi_awaddr_i,
  input  logic                      s_axi_awvalid_i,
  output logic                      s_axi_awready_o,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata_i,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
  input  logic                      s_axi_wvalid_i,
  output logic                      s_axi_wready_o,
  output logic [1:0]                s_axi_bresp_o,
  output logic                      s_axi_bvalid_o,
  input  logic                      s_axi_bready_i,
  input  logic [C_ADDR_WIDTH+1:0]   s_axi_araddr_i,
  input  logic                      s_axi_arvalid_i,
  output logic                      s_axi_arready_o,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata_o,
  output logic [1:0]                s_axi_rresp_o,
  output logic                      s_axi_rvalid_o,
  input  logic                      s_axi_rready_i,

  output logic [C_ADDR_WIDTH-1:0]   up_wr_addr_o,
  output logic [C_DATA_WIDTH/8-1:0] up_wr_be_o,
  output logic                      up_wr_req_o,
  output logic [C_DATA_WIDTH-1:0]   up_wr_din_o,
  input  logic                      up_wr_ack_i,
  output logic [C_ADDR_WIDTH-1:0]   up_rd_addr_o,
  output logic                      up_rd_req_o,
  input  logic [C_DATA_WIDTH-1:0]   up_rd_dout_i,
  input  logic                      up_rd_ack_i
);

  localparam int AW = C_ADDR_WIDTH + 2;
  localparam int SW = C_DATA_WIDTH / 8;
  localparam int CW = $clog2(C_TIMEOUT + 1);
  // Counter value in the C_TIMEOUT-th wait cycle; an ack there still wins.
  localparam logic [CW-1:0] TO_LAST = CW'(C_TIMEOUT - 1);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_REQ  = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] WR_RESP = 2'd3;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RD_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]              wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [C_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SW-1:0]           wr_be_q, wr_be_d;
  logic [C_DATA_WIDTH-1:0] wr_din_q, wr_din_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [CW-1:0]           wr_cnt_q, wr_cnt_d;

  logic [1:0]              rd_state_q, rd_state_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;

  logic awready_s, wready_s, arready_s;
  logic aw_hs_s, w_hs_s, ar_hs_s;
  logic unused_addr_lsb_s;

  // Ready/valid are pure decodes of state flops, so no AXI input reaches an AXI output.
  assign awready_s = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign wready_s  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign arready_s = (rd_state_q == RD_IDLE);
  assign aw_hs_s   = s_axi_awvalid_i && awready_s;
  assign w_hs_s    = s_axi_wvalid_i && wready_s;
  assign ar_hs_s   = s_axi_arvalid_i && arready_s;

  assign unused_addr_lsb_s = ^{s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0]};

  assign s_axi_awready_o = awready_s;
  assign s_axi_wready_o  = wready_s;
  assign s_axi_bvalid_o  = (wr_state_q == WR_RESP);
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_arready_o = arready_s;
  assign s_axi_rvalid_o  = (rd_state_q == RD_RESP);
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rdata_o   = rdata_q;

  assign up_wr_req_o  = (wr_state_q == WR_REQ);
  assign up_wr_addr_o = wr_addr_q;
  assign up_wr_be_o   = wr_be_q;
  assign up_wr_din_o  = wr_din_q;
  assign up_rd_req_o  = (rd_state_q == RD_REQ);
  assign up_rd_addr_o = rd_addr_q;

  // Write path next-state: collect AW and W in any order, pulse req, await ack or timeout.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_addr_d  = wr_addr_q;
    wr_be_d    = wr_be_q;
    wr_din_d   = wr_din_q;
    bresp_d    = bresp_q;
    wr_cnt_d   = wr_cnt_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs_s) begin
          wr_addr_d = s_axi_awaddr_i[AW-1:2];
          aw_held_d = 1'b1;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          wr_be_d  = s_axi_wstrb_i;
          wr_din_d = s_axi_wdata_i;
          w_held_d = 1'b1;
        end else begin
          w_held_d = w_held_q;
        end
        if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
          wr_state_d = WR_REQ;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_REQ: begin
        wr_cnt_d   = {CW{1'b0}};
        wr_state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (up_wr_ack_i) begin
          bresp_d    = RESP_OKAY;
          wr_state_d = WR_RESP;
        end else if (wr_cnt_q == TO_LAST) begin
          bresp_d    = RESP_SLVERR;
          wr_state_d = WR_RESP;
        end else begin
          wr_cnt_d   = wr_cnt_q + CW'(1);
        end
      end
      WR_RESP: begin
        if (s_axi_bready_i) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
      end
    endcase
  end

  // Read path next-state: capture AR, pulse req, register data or SLVERR on timeout.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rd_addr_d  = s_axi_araddr_i[AW-1:2];
          rd_state_d = RD_REQ;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_REQ: begin
        rd_cnt_d   = {CW{1'b0}};
        rd_state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (up_rd_ack_i) begin
          rdata_d    = up_rd_dout_i;
          rresp_d    = RESP_OKAY;
          rd_state_d = RD_RESP;
        end else if (rd_cnt_q == TO_LAST) begin
          rdata_d    = {C_DATA_WIDTH{1'b0}};
          rresp_d    = RESP_SLVERR;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d   = rd_cnt_q + CW'(1);
        end
      end
      RD_RESP: begin
        if (s_axi_rready_i) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_RESP;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // State and datapath registers for both paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_addr_q  <= {C_ADDR_WIDTH{1'b0}};
      wr_be_q    <= {SW{1'b0}};
      wr_din_q   <= {C_DATA_WIDTH{1'b0}};
      bresp_q    <= RESP_OKAY;
      wr_cnt_q   <= {CW{1'b0}};
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= {C_ADDR_WIDTH{1'b0}};
      rdata_q    <= {C_DATA_WIDTH{1'b0}};
      rresp_q    <= RESP_OKAY;
      rd_cnt_q   <= {CW{1'b0}};
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
      wr_din_q   <= wr_din_d;
      bresp_q    <= bresp_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_up_bridge.sv
// Directed bench for axi_lite_up_bridge with a short timeout (C_TIMEOUT = 8).
module tb_axi_lite_up_bridge;

  logic        clk;
  logic        rst_n;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_be;
  logic        wr_req;
  logic [31:0] wr_din;
  logic        wr_ack;
  logic [9:0]  rd_addr;
  logic        rd_req;
  logic [31:0] rd_dout;
  logic        rd_ack;

  int n_assert;
  int n_fail;

  axi_lite_up_bridge #(
    .C_ADDR_WIDTH(10),
    .C_DATA_WIDTH(32),
    .C_TIMEOUT   (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi_awaddr_i (awaddr),
    .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready),
    .s_axi_wdata_i  (wdata),
    .s_axi_wstrb_i  (wstrb),
    .s_axi_wvalid_i (wvalid),
    .s_axi_wready_o (wready),
    .s_axi_bresp_o  (bresp),
    .s_axi_bvalid_o (bvalid),
    .s_axi_bready_i (bready),
    .s_axi_araddr_i (araddr),
    .s_axi_arvalid_i(arvalid),
    .s_axi_arready_o(arready),
    .s_axi_rdata_o  (rdata),
    .s_axi_rresp_o  (rresp),
    .s_axi_rvalid_o (rvalid),
    .s_axi_rready_i (rready),
    .up_wr_addr_o   (wr_addr),
    .up_wr_be_o     (wr_be),
    .up_wr_req_o    (wr_req),
    .up_wr_din_o    (wr_din),
    .up_wr_ack_i    (wr_ack),
    .up_rd_addr_o   (rd_addr),
    .up_rd_req_o    (rd_req),
    .up_rd_dout_i   (rd_dout),
    .up_rd_ack_i    (rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0; awaddr = 12'h000; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    wvalid = 1'b0; bready = 1'b0; araddr = 12'h000; arvalid = 1'b0; rready = 1'b0;
    wr_ack = 1'b0; rd_ack = 1'b0; rd_dout = 32'h0;
    tick();
    tick();
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_be", 32'(wr_be), 32'd0);
    check("rst_wr_din", wr_din, 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write, ack 3 cycles after req.
    awaddr = 12'h010; awvalid = 1'b1; wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("w1_req", 32'(wr_req), 32'd1);
    check("w1_addr", 32'(wr_addr), 32'h004);
    check("w1_be", 32'(wr_be), 32'hF);
    check("w1_din", wr_din, 32'hA5A5_0001);
    check("w1_awready_busy", 32'(awready), 32'd0);
    tick();
    check("w1_req_pulse", 32'(wr_req), 32'd0);
    tick();
    tick();
    wr_ack = 1'b1;
    check("w1_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    wr_ack = 1'b0;
    check("w1_bvalid", 32'(bvalid), 32'd1);
    check("w1_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("w1_bvalid_done", 32'(bvalid), 32'd0);
    check("w1_awready_idle", 32'(awready), 32'd1);

    // W two cycles before AW, wstrb 3; ack in the req cycle must be ignored.
    wdata = 32'h0000_BEEF; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w2_wready_drop", 32'(wready), 32'd0);
    check("w2_awready_open", 32'(awready), 32'd1);
    check("w2_no_req", 32'(wr_req), 32'd0);
    tick();
    check("w2_no_req2", 32'(wr_req), 32'd0);
    awaddr = 12'h020; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("w2_req", 32'(wr_req), 32'd1);
    check("w2_addr", 32'(wr_addr), 32'h008);
    check("w2_be", 32'(wr_be), 32'h3);
    check("w2_din", wr_din, 32'h0000_BEEF);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("w2_same_cycle_ack", 32'(bvalid), 32'd0);
    tick();
    check("w2_still_wait", 32'(bvalid), 32'd0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("w2_bvalid", 32'(bvalid), 32'd1);
    check("w2_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Read at the top address with rready backpressure.
    araddr = 12'hFFC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("r1_req", 32'(rd_req), 32'd1);
    check("r1_addr", 32'(rd_addr), 32'h3FF);
    check("r1_arready_busy", 32'(arready), 32'd0);
    tick();
    rd_ack = 1'b1; rd_dout = 32'h1234_5678;
    tick();
    rd_ack = 1'b0; rd_dout = 32'hDEAD_BEEF;
    check("r1_rvalid", 32'(rvalid), 32'd1);
    check("r1_rdata", rdata, 32'h1234_5678);
    check("r1_rresp", 32'(rresp), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r1_hold_rvalid", 32'(rvalid), 32'd1);
      check("r1_hold_rdata", rdata, 32'h1234_5678);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r1_rvalid_done", 32'(rvalid), 32'd0);
    check("r1_arready_idle", 32'(arready), 32'd1);

    // Read timeout after 8 wait cycles, late ack at cycle 12 ignored.
    araddr = 12'h008; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("to_rvalid_wait", 32'(rvalid), 32'd0);
    end
    tick();
    check("to_rvalid", 32'(rvalid), 32'd1);
    check("to_rresp", 32'(rresp), 32'h2);
    check("to_rdata", rdata, 32'h0);
    tick();
    tick();
    rd_ack = 1'b1; rd_dout = 32'hFFFF_FFFF;
    tick();
    rd_ack = 1'b0;
    check("to_late_rdata", rdata, 32'h0);
    check("to_late_rresp", 32'(rresp), 32'h2);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    araddr = 12'h00C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("r2_addr", 32'(rd_addr), 32'h003);
    tick();
    rd_ack = 1'b1; rd_dout = 32'hCAFE_F00D;
    tick();
    rd_ack = 1'b0;
    check("r2_rvalid", 32'(rvalid), 32'd1);
    check("r2_rdata", rdata, 32'hCAFE_F00D);
    check("r2_rresp", 32'(rresp), 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Write timeout with no ack.
    awaddr = 12'h030; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("wto_bvalid_wait", 32'(bvalid), 32'd0);
    end
    tick();
    check("wto_bvalid", 32'(bvalid), 32'd1);
    check("wto_bresp", 32'(bresp), 32'h2);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Concurrent write and read, acks in the same cycle.
    awaddr = 12'h040; awvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h080; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("cc_wr_req", 32'(wr_req), 32'd1);
    check("cc_rd_req", 32'(rd_req), 32'd1);
    check("cc_wr_addr", 32'(wr_addr), 32'h010);
    check("cc_rd_addr", 32'(rd_addr), 32'h020);
    tick();
    wr_ack = 1'b1; rd_ack = 1'b1; rd_dout = 32'h3333_4444;
    tick();
    wr_ack = 1'b0; rd_ack = 1'b0; rd_dout = 32'h0;
    check("cc_bvalid", 32'(bvalid), 32'd1);
    check("cc_bresp", 32'(bresp), 32'd0);
    check("cc_rvalid", 32'(rvalid), 32'd1);
    check("cc_rresp", 32'(rresp), 32'd0);
    check("cc_rdata", rdata, 32'h3333_4444);
    check("cc_wr_din", wr_din, 32'h1111_2222);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("cc_bvalid_done", 32'(bvalid), 32'd0);
    check("cc_rvalid_done", 32'(rvalid), 32'd0);

    // Reset during WR_WAIT, late ack ignored, then a full write.
    awaddr = 12'h004; awvalid = 1'b1; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_awready", 32'(awready), 32'd1);
    check("mr_wready", 32'(wready), 32'd1);
    check("mr_arready", 32'(arready), 32'd1);
    check("mr_bvalid", 32'(bvalid), 32'd0);
    check("mr_wr_addr", 32'(wr_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("mr_late_ack", 32'(bvalid), 32'd0);
    check("mr_late_ack_rdy", 32'(awready), 32'd1);
    awaddr = 12'h3FC; awvalid = 1'b1; wdata = 32'h7654_3210; wstrb = 4'hC; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("mr_w_req", 32'(wr_req), 32'd1);
    check("mr_w_addr", 32'(wr_addr), 32'h0FF);
    check("mr_w_be", 32'(wr_be), 32'hC);
    check("mr_w_din", wr_din, 32'h7654_3210);
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("mr_w_bvalid", 32'(bvalid), 32'd1);
    check("mr_w_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("mr_w_done", 32'(bvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
